// File: rtl/branch_tag_alloc.sv
// branch_tag_alloc: gives each decoded branch a one-hot tag and stamps every instruction with the speculative branch mask.
// Latency: one cycle, through a one-entry registered output stage.
// Backpressure: in_ready drops on reset, on a kill, when the output is held, or when a branch finds no free tag.
// Optional feature macro: BRTAG_CLEAN_BYPASS_EN (a tag freed by a clean may be allocated in the same cycle).
module branch_tag_alloc #(
  parameter int NUM_TAGS = 4,
  localparam int TAG_W = $clog2(NUM_TAGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic                in_is_br,
  output logic                in_ready,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [NUM_TAGS-1:0] out_mask,
  output logic [TAG_W-1:0]    out_tag,
  output logic                out_is_br,
  input  logic                bc_valid,
  input  logic [TAG_W-1:0]    bc_tag,
  input  logic                bc_clean,
  output logic [TAG_W:0]      free_cnt
);

  logic [NUM_TAGS-1:0] free_q;
  logic [NUM_TAGS-1:0] cur_mask_q;
  logic [NUM_TAGS-1:0] snap_q [NUM_TAGS];
  logic                out_valid_q;
  logic [NUM_TAGS-1:0] out_mask_q;
  logic [TAG_W-1:0]    out_tag_q;
  logic                out_is_br_q;
  logic [TAG_W:0]      free_cnt_q;

  logic                clean;
  logic                kill;
  logic [NUM_TAGS-1:0] bc_onehot;
  logic [NUM_TAGS-1:0] clean_bits;
  logic [NUM_TAGS-1:0] kill_set;
  logic [NUM_TAGS-1:0] avail;
  logic [NUM_TAGS-1:0] new_mask;
  logic [NUM_TAGS-1:0] free_n;
  logic [NUM_TAGS-1:0] cur_mask_n;
  logic [TAG_W-1:0]    alloc_idx;
  logic                any_avail;
  logic                accept;
  logic                accept_br;
  logic                out_hit;

  assign clean      = bc_valid & bc_clean;
  assign kill       = bc_valid & ~bc_clean;
  assign bc_onehot  = NUM_TAGS'(1) << bc_tag;
  assign clean_bits = clean ? bc_onehot : '0;

  // Kill set: the resolved tag plus every tag allocated while it was still in flight.
  always_comb begin
    kill_set = bc_onehot;
    for (int u = 0; u < NUM_TAGS; u++) begin
      if (snap_q[u][bc_tag]) kill_set[u] = 1'b1;
    end
  end

`ifdef BRTAG_CLEAN_BYPASS_EN
  // A tag being cleaned this cycle can be handed straight to a new branch.
  assign avail = free_q | clean_bits;
`else
  assign avail = free_q;
`endif

  // Lowest-index available tag wins the allocation.
  always_comb begin
    alloc_idx = '0;
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (avail[i]) alloc_idx = TAG_W'(i);
    end
  end

  assign any_avail = |avail;
  assign in_ready  = ~rst & ~kill & (~out_valid_q | out_ready) & ~(in_is_br & ~any_avail);
  assign accept    = in_valid & in_ready;
  assign accept_br = accept & in_is_br;
  // A same-cycle clean wins over the mask being stamped on the incoming instruction.
  assign new_mask  = cur_mask_q & ~clean_bits;
  // The held instruction dies if it sits under the killed branch or is that branch itself.
  assign out_hit   = out_mask_q[bc_tag] | (out_is_br_q & (out_tag_q == bc_tag));

  // Next free vector and speculative mask: release on clean/kill first, then allocate.
  always_comb begin
    free_n     = free_q | clean_bits;
    cur_mask_n = cur_mask_q & ~clean_bits;
    if (kill) begin
      free_n     = free_n | kill_set;
      cur_mask_n = cur_mask_n & ~kill_set;
    end
    if (accept_br) begin
      free_n[alloc_idx]     = 1'b0;
      cur_mask_n[alloc_idx] = 1'b1;
    end
  end

  function automatic logic [TAG_W:0] popcount(input logic [NUM_TAGS-1:0] v);
    logic [TAG_W:0] c;
    c = '0;
    for (int i = 0; i < NUM_TAGS; i++) c = c + (TAG_W+1)'(v[i]);
    return c;
  endfunction

  // Tag bookkeeping: free list, current mask, dependency snapshots, free count.
  always_ff @(posedge clk) begin
    if (rst) begin
      free_q     <= '1;
      cur_mask_q <= '0;
      free_cnt_q <= (TAG_W+1)'(NUM_TAGS);
      for (int u = 0; u < NUM_TAGS; u++) snap_q[u] <= '0;
    end else begin
      free_q     <= free_n;
      cur_mask_q <= cur_mask_n;
      free_cnt_q <= popcount(free_n);
      for (int u = 0; u < NUM_TAGS; u++) begin
        if (accept_br && (alloc_idx == TAG_W'(u))) snap_q[u] <= new_mask;
        else                                        snap_q[u] <= snap_q[u] & ~clean_bits;
      end
    end
  end

  // One-entry output stage: load on accept, drain on out_ready, squash on a matching kill.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_mask_q  <= '0;
      out_tag_q   <= '0;
      out_is_br_q <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_mask_q  <= new_mask;
      out_tag_q   <= accept_br ? alloc_idx : '0;
      out_is_br_q <= in_is_br;
    end else begin
      out_mask_q <= out_mask_q & ~clean_bits;
      if (out_ready || (kill && out_hit)) out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_mask  = out_mask_q;
  assign out_tag   = out_tag_q;
  assign out_is_br = out_is_br_q;
  assign free_cnt  = free_cnt_q;

endmodule

// File: tb/tb_branch_tag_alloc.sv
// Bench for branch_tag_alloc: directed scenarios followed by random traffic.
// In-flight branches are modelled as an age-ordered list of tags; expected outputs sit in a scoreboard queue.
// A monitor process compares the presented output against the scoreboard head.
module tb_branch_tag_alloc;
  localparam int NUM_TAGS = 4;
  localparam int TAG_W = 2;

  logic clk = 1'b0;
  logic rst, in_valid, in_is_br, in_ready, out_valid, out_ready, out_is_br, bc_valid, bc_clean;
  logic [NUM_TAGS-1:0] out_mask;
  logic [TAG_W-1:0] out_tag, bc_tag;
  logic [TAG_W:0] free_cnt;

  int checks = 0;
  int failures = 0;
  bit mon_en = 0;

  typedef struct {
    logic [NUM_TAGS-1:0] mask;
    logic [TAG_W-1:0]    tag;
    logic                is_br;
  } exp_t;

  exp_t sb[$];
  int   live[$];

  always #5 clk = ~clk;

  branch_tag_alloc #(.NUM_TAGS(NUM_TAGS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_is_br(in_is_br), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_mask(out_mask), .out_tag(out_tag),
    .out_is_br(out_is_br), .bc_valid(bc_valid), .bc_tag(bc_tag), .bc_clean(bc_clean),
    .free_cnt(free_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NUM_TAGS-1:0] live_mask();
    logic [NUM_TAGS-1:0] m;
    m = '0;
    foreach (live[i]) m[live[i]] = 1'b1;
    return m;
  endfunction

  function automatic bit is_live(input int t);
    foreach (live[i]) if (live[i] == t) return 1'b1;
    return 1'b0;
  endfunction

  // Monitor: compare the presented output with the scoreboard head, pop on handshake.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (mon_en) begin
        chk("out_valid", out_valid, sb.size() != 0);
        if (out_valid === 1'b1 && sb.size() != 0) begin
          chk("out_mask", out_mask, sb[0].mask);
          chk("out_is_br", out_is_br, sb[0].is_br);
          if (sb[0].is_br) chk("out_tag", out_tag, sb[0].tag);
          if (out_ready) void'(sb.pop_front());
        end
      end
    end
  end

  // Reference model, evaluated just before the clock edge with this cycle's inputs.
  task automatic model_step();
    logic [NUM_TAGS-1:0] lm, avail, cb, nm;
    int  tag, idx;
    bit  exp_rdy, acc;
    lm = live_mask();
    cb = (bc_valid && bc_clean) ? (4'b0001 << bc_tag) : 4'b0000;
    if (mon_en) chk("free_cnt", free_cnt, NUM_TAGS - live.size());
`ifdef BRTAG_CLEAN_BYPASS_EN
    avail = ~lm | cb;
`else
    avail = ~lm;
`endif
    exp_rdy = !rst && !(bc_valid && !bc_clean) && (out_ready || sb.size() == 0)
              && !(in_is_br && avail == 0);
    if (mon_en) chk("in_ready", in_ready, exp_rdy);
    if (rst) begin
      live.delete();
      sb.delete();
      return;
    end
    acc = in_valid && exp_rdy;
    tag = 0;
    for (int i = NUM_TAGS - 1; i >= 0; i--) if (avail[i]) tag = i;
    if (bc_valid) begin
      assert (is_live(int'(bc_tag))) else $error("broadcast on a tag that is not in flight");
      if (bc_clean) begin
        for (int i = 0; i < live.size(); i++)
          if (live[i] == int'(bc_tag)) begin live.delete(i); break; end
        foreach (sb[i]) sb[i].mask = sb[i].mask & ~cb;
      end else begin
        idx = live.size();
        for (int i = 0; i < live.size(); i++) if (live[i] == int'(bc_tag)) begin idx = i; break; end
        while (live.size() > idx) void'(live.pop_back());
        for (int i = sb.size() - 1; i >= 0; i--)
          if (sb[i].mask[bc_tag] || (sb[i].is_br && sb[i].tag == bc_tag)) sb.delete(i);
      end
    end
    if (acc) begin
      nm = live_mask();
      sb.push_back('{mask: nm, tag: (in_is_br ? TAG_W'(tag) : '0), is_br: in_is_br});
      if (in_is_br) live.push_back(tag);
    end
  endtask

  task automatic step(input bit v, input bit br, input bit ordy, input bit bcv,
                      input int bct, input bit bcc, input bit r);
    @(negedge clk);
    in_valid = v; in_is_br = br; out_ready = ordy;
    bc_valid = bcv; bc_tag = TAG_W'(bct); bc_clean = bcc; rst = r;
    #4;
    model_step();
  endtask

  task automatic reset_seq();
    step(1, 1, 0, 0, 0, 1, 1);
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_free_cnt", free_cnt, 4);
    chk("rst_out_mask", out_mask, 0);
  endtask

  task automatic clean_all();
    while (live.size() != 0) step(0, 0, 1, 1, live[0], 1, 0);
    step(0, 0, 1, 0, 0, 1, 0);
  endtask

  initial begin
    bit v, br, ordy, bcv, bcc, r;
    int t;
    rst = 1; in_valid = 0; in_is_br = 0; out_ready = 0;
    bc_valid = 0; bc_tag = '0; bc_clean = 1;
    reset_seq();
    mon_en = 1;

    // Four back-to-back branches, a stalled fifth, then a non-branch under the full mask.
    for (int i = 0; i < 4; i++) step(1, 1, 1, 0, 0, 1, 0);
    #2;
    chk("t1_tag3", out_tag, 3);
    chk("t1_mask3", out_mask, 4'b0111);
    step(1, 1, 1, 0, 0, 1, 0);
    chk("t1_stall_rdy", in_ready, 0);
    chk("t1_stall_cnt", free_cnt, 0);
    step(1, 0, 1, 0, 0, 1, 0);
    #2;
    chk("t1_nonbr_mask", out_mask, 4'b1111);
    clean_all();

    // Clean of a middle tag, then reuse of that tag.
    for (int i = 0; i < 3; i++) step(1, 1, 1, 0, 0, 1, 0);
    step(1, 0, 1, 1, 1, 1, 0);
    #2;
    chk("t2_mask", out_mask, 4'b0101);
    chk("t2_cnt", free_cnt, 2);
    step(1, 1, 1, 0, 0, 1, 0);
    #2;
    chk("t2_tag", out_tag, 1);
    chk("t2_tag_mask", out_mask, 4'b0101);
    clean_all();

    // Kill of tag 1 with all tags allocated and the output held.
    for (int i = 0; i < 4; i++) step(1, 1, 1, 0, 0, 1, 0);
    step(1, 0, 0, 1, 1, 0, 0);
    chk("t3_kill_rdy", in_ready, 0);
    #2;
    chk("t3_squash", out_valid, 0);
    chk("t3_cnt", free_cnt, 3);
    step(1, 1, 1, 0, 0, 1, 0);
    #2;
    chk("t3_realloc_tag", out_tag, 1);
    chk("t3_realloc_mask", out_mask, 4'b0001);
    clean_all();

    // Clean while the output is held.
    for (int i = 0; i < 3; i++) step(1, 1, 1, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0, 1, 0);
    #2;
    chk("t4_mask", out_mask, 4'b0010);
    chk("t4_tag", out_tag, 2);
    clean_all();

    // Full tags, waiting branch, clean on tag 2.
    for (int i = 0; i < 4; i++) step(1, 1, 1, 0, 0, 1, 0);
    step(1, 1, 1, 1, 2, 1, 0);
`ifdef BRTAG_CLEAN_BYPASS_EN
    chk("t5_bypass_rdy", in_ready, 1);
`else
    chk("t5_bypass_rdy", in_ready, 0);
`endif
    step(1, 1, 1, 0, 0, 1, 0);
    clean_all();

    // Reset in the middle of traffic.
    step(1, 1, 1, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 1, 0);
    reset_seq();

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      v    = ($urandom_range(0, 9) < 7);
      br   = $urandom_range(0, 1);
      ordy = ($urandom_range(0, 3) != 0);
      bcv  = (live.size() != 0) && ($urandom_range(0, 4) == 0);
      t    = (live.size() != 0) ? live[$urandom_range(0, live.size() - 1)] : 0;
      bcc  = ($urandom_range(0, 3) != 0);
      r    = ($urandom_range(0, 299) == 0);
      step(v, br, ordy, bcv, t, bcc, r);
    end
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
